ticket_change_dispenser: RTL and testbench

//  Downstream stage of the ticket vending FSM. When the pay stage completes, it latches
//  the fare, the money inserted and the ticket count. It then issues tickets one at a time

---
 rtl/ticket_change_dispenser.sv | 113 +++++++++++
 tb/tb_ticket_change_dispenser.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/ticket_change_dispenser.sv
// Ticket/change dispenser: latches the fare totals, issues tickets one at a time over
// valid/ready, then pays the change out largest coin first and pulses done.
module ticket_change_dispenser #(
  parameter logic [5:0] DENOM_0 = 6'd50,
  parameter logic [5:0] DENOM_1 = 6'd10,
  parameter logic [5:0] DENOM_2 = 6'd5,
  parameter logic [5:0] DENOM_3 = 6'd1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] total_money,
  input  logic [7:0] cost_of_ticket,
  input  logic [2:0] ticket_count,
  output logic       busy,
  output logic       ticket_valid,
  input  logic       ticket_ready,
  output logic       coin_valid,
  output logic [5:0] coin_value,
  input  logic       coin_ready,
  output logic [7:0] change_total,
  output logic       done,
  output logic       error
);

  typedef enum logic [1:0] {IDLE, TICKET, CHANGE, DONE} state_t;

  state_t     state_q, state_d;
  logic [7:0] remaining_q, remaining_d;
  logic [2:0] tkt_left_q, tkt_left_d;
  logic [7:0] change_total_q, change_total_d;
  logic       error_q, error_d;
  logic [5:0] coin_pick;

  // Greedy denomination choice, decoded from the registered remaining amount.
  always_comb begin
    if (remaining_q >= {2'b00, DENOM_0})      coin_pick = DENOM_0;
    else if (remaining_q >= {2'b00, DENOM_1}) coin_pick = DENOM_1;
    else if (remaining_q >= {2'b00, DENOM_2}) coin_pick = DENOM_2;
    else                                      coin_pick = DENOM_3;
  end

  always_comb begin
    state_d        = state_q;
    remaining_d    = remaining_q;
    tkt_left_d     = tkt_left_q;
    change_total_d = change_total_q;
    error_d        = 1'b0;
    ticket_valid   = 1'b0;
    coin_valid     = 1'b0;
    coin_value     = 6'd0;
    done           = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (total_money >= cost_of_ticket) begin
            remaining_d    = total_money - cost_of_ticket;
            change_total_d = total_money - cost_of_ticket;
            tkt_left_d     = ticket_count;
            state_d        = (ticket_count != 3'd0) ? TICKET : CHANGE;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      TICKET: begin
        ticket_valid = 1'b1;
        if (ticket_ready) begin
          tkt_left_d = tkt_left_q - 3'd1;
          // With no change owed, the last ticket goes straight to DONE to save a cycle.
          if (tkt_left_q == 3'd1)
            state_d = (remaining_q == 8'd0) ? DONE : CHANGE;
        end
      end
      CHANGE: begin
        if (remaining_q == 8'd0) begin
          state_d = DONE;
        end else begin
          coin_valid = 1'b1;
          coin_value = coin_pick;
          if (coin_ready)
            remaining_d = remaining_q - {2'b00, coin_pick};
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      remaining_q    <= 8'd0;
      tkt_left_q     <= 3'd0;
      change_total_q <= 8'd0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      remaining_q    <= remaining_d;
      tkt_left_q     <= tkt_left_d;
      change_total_q <= change_total_d;
      error_q        <= error_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign change_total = change_total_q;
  assign error        = error_q;

endmodule

// File: tb/tb_ticket_change_dispenser.sv
// Directed bench for ticket_change_dispenser: hand-computed ticket/coin sequences,
// error pulse, stall behaviour and mid-transaction reset.
module tb_ticket_change_dispenser;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] total_money;
  logic [7:0] cost_of_ticket;
  logic [2:0] ticket_count;
  logic       busy;
  logic       ticket_valid;
  logic       ticket_ready;
  logic       coin_valid;
  logic [5:0] coin_value;
  logic       coin_ready;
  logic [7:0] change_total;
  logic       done;
  logic       error;

  int errors = 0;
  int checks = 0;

  ticket_change_dispenser dut (
    .clk(clk), .reset(reset), .start(start),
    .total_money(total_money), .cost_of_ticket(cost_of_ticket), .ticket_count(ticket_count),
    .busy(busy), .ticket_valid(ticket_valid), .ticket_ready(ticket_ready),
    .coin_valid(coin_valid), .coin_value(coin_value), .coin_ready(coin_ready),
    .change_total(change_total), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Checks every output in one go: busy, ticket_valid, coin_valid, coin_value, done, error.
  task automatic chk_out(input string tag, input logic b, input logic tv, input logic cv,
                         input logic [5:0] val, input logic d, input logic e);
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
    chk({tag, ".ticket_valid"}, {31'd0, ticket_valid}, {31'd0, tv});
    chk({tag, ".coin_valid"}, {31'd0, coin_valid}, {31'd0, cv});
    chk({tag, ".coin_value"}, {26'd0, coin_value}, {26'd0, val});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
    chk({tag, ".error"}, {31'd0, error}, {31'd0, e});
    $display("step %-10s busy=%0d tv=%0d cv=%0d val=%0d chg=%0d done=%0d err=%0d",
             tag, busy, ticket_valid, coin_valid, coin_value, change_total, done, error);
  endtask

  task automatic do_start(input logic [7:0] t, input logic [7:0] c, input logic [2:0] n);
    total_money = t; cost_of_ticket = c; ticket_count = n; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    logic [5:0] coins97 [5];
    coins97[0] = 6'd50; coins97[1] = 6'd10; coins97[2] = 6'd5;
    coins97[3] = 6'd1;  coins97[4] = 6'd1;

    reset = 1'b1; start = 1'b0; total_money = 8'd0; cost_of_ticket = 8'd0;
    ticket_count = 3'd0; ticket_ready = 1'b1; coin_ready = 1'b1;
    tick(); tick();
    chk_out("reset", 0, 0, 0, 6'd0, 0, 0);
    chk("reset.change_total", {24'd0, change_total}, 32'd0);
    reset = 1'b0;
    tick();

    // 40 - 30 with two tickets
    do_start(8'd40, 8'd30, 3'd2);
    chk_out("s1.tkt1", 1, 1, 0, 6'd0, 0, 0);
    chk("s1.change_total", {24'd0, change_total}, 32'd10);
    tick(); chk_out("s1.tkt2", 1, 1, 0, 6'd0, 0, 0);
    tick(); chk_out("s1.coin10", 1, 0, 1, 6'd10, 0, 0);
    tick(); chk_out("s1.eval", 1, 0, 0, 6'd0, 0, 0);
    tick(); chk_out("s1.done", 1, 0, 0, 6'd0, 1, 0);
    tick(); chk_out("s1.idle", 0, 0, 0, 6'd0, 0, 0);

    // 97 - 30 with one ticket: coins 50,10,5,1,1
    do_start(8'd97, 8'd30, 3'd1);
    chk_out("s2.tkt", 1, 1, 0, 6'd0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      tick(); chk_out($sformatf("s2.coin%0d", i), 1, 0, 1, coins97[i], 0, 0);
    end
    tick(); chk_out("s2.eval", 1, 0, 0, 6'd0, 0, 0);
    tick(); chk_out("s2.done", 1, 0, 0, 6'd0, 1, 0);
    chk("s2.change_total", {24'd0, change_total}, 32'd67);
    tick(); chk_out("s2.idle", 0, 0, 0, 6'd0, 0, 0);

    // Underpayment: error pulse, nothing latched
    do_start(8'd10, 8'd25, 3'd1);
    chk_out("s4.err", 0, 0, 0, 6'd0, 0, 1);
    chk("s4.change_total", {24'd0, change_total}, 32'd67);
    tick(); chk_out("s4.after", 0, 0, 0, 6'd0, 0, 0);

    // Exact fare, four tickets, done straight after the last ticket
    do_start(8'd20, 8'd20, 3'd4);
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("s3.tkt%0d", i), 1, 1, 0, 6'd0, 0, 0);
      tick();
    end
    chk_out("s3.done", 1, 0, 0, 6'd0, 1, 0);
    chk("s3.change_total", {24'd0, change_total}, 32'd0);
    tick(); chk_out("s3.idle", 0, 0, 0, 6'd0, 0, 0);

    // Change 15 with the hopper stalled for three cycles; a start during the stall is ignored
    coin_ready = 1'b0;
    do_start(8'd45, 8'd30, 3'd0);
    chk_out("s5.stall0", 1, 0, 1, 6'd10, 0, 0);
    total_money = 8'd99; cost_of_ticket = 8'd0; ticket_count = 3'd3; start = 1'b1;
    tick(); start = 1'b0;
    chk_out("s5.stall1", 1, 0, 1, 6'd10, 0, 0);
    chk("s5.change_total", {24'd0, change_total}, 32'd15);
    tick(); chk_out("s5.stall2", 1, 0, 1, 6'd10, 0, 0);
    coin_ready = 1'b1;
    tick(); chk_out("s5.coin5", 1, 0, 1, 6'd5, 0, 0);
    tick(); chk_out("s5.eval", 1, 0, 0, 6'd0, 0, 0);
    tick(); chk_out("s5.done", 1, 0, 0, 6'd0, 1, 0);
    tick(); chk_out("s5.idle", 0, 0, 0, 6'd0, 0, 0);
    chk("s5.change_hold", {24'd0, change_total}, 32'd15);

    // Reset during the second coin, then a fresh transaction
    do_start(8'd97, 8'd30, 3'd0);
    chk_out("s6.coin50", 1, 0, 1, 6'd50, 0, 0);
    tick(); chk_out("s6.coin10", 1, 0, 1, 6'd10, 0, 0);
    reset = 1'b1;
    tick(); reset = 1'b0;
    chk_out("s6.reset", 0, 0, 0, 6'd0, 0, 0);
    chk("s6.change_total", {24'd0, change_total}, 32'd0);
    tick(); chk_out("s6.nodone", 0, 0, 0, 6'd0, 0, 0);
    do_start(8'd40, 8'd30, 3'd2);
    chk_out("s6.tkt1", 1, 1, 0, 6'd0, 0, 0);
    tick(); chk_out("s6.tkt2", 1, 1, 0, 6'd0, 0, 0);
    tick(); chk_out("s6.coin", 1, 0, 1, 6'd10, 0, 0);
    tick(); tick(); chk_out("s6.done", 1, 0, 0, 6'd0, 1, 0);
    chk("s6.change_new", {24'd0, change_total}, 32'd10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
